// File: rtl/cross_bar_rr.sv
// N-master x M-slave request/ack/response crossbar. Each slave owns a small
// arbiter FSM that grants one master at a time in round-robin order.
module cross_bar_rr #(
    parameter int N_MASTERS  = 4,
    parameter int N_SLAVES   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTERS-1:0]             m_req,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
    input  logic [N_MASTERS-1:0]             m_cmd,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_wdata,
    output logic [N_MASTERS-1:0]             m_ack,
    output logic [N_MASTERS-1:0]             m_resp,
    output logic [N_MASTERS*DATA_WIDTH-1:0]  m_rdata,
    output logic [N_SLAVES-1:0]              s_req,
    output logic [N_SLAVES*ADDR_WIDTH-1:0]   s_addr,
    output logic [N_SLAVES-1:0]              s_cmd,
    output logic [N_SLAVES*DATA_WIDTH-1:0]   s_wdata,
    input  logic [N_SLAVES-1:0]              s_ack,
    input  logic [N_SLAVES-1:0]              s_resp,
    input  logic [N_SLAVES*DATA_WIDTH-1:0]   s_rdata,
    output logic [2*N_SLAVES-1:0]            dbg_state
);

    // Handshake: a master holds m_req with stable addr/cmd/wdata until m_ack;
    // a transfer happens on a cycle where s_req and s_ack are both high.
    localparam int SW = $clog2(N_SLAVES);
    localparam int MW = $clog2(N_MASTERS);

    // dbg_state encoding per slave: 0 idle, 1 request, 2 wait for read data
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]            state_q [N_SLAVES];
    logic [1:0]            state_d [N_SLAVES];
    logic [MW-1:0]         owner_q [N_SLAVES];
    logic [MW-1:0]         owner_d [N_SLAVES];
    logic [MW-1:0]         ptr_q   [N_SLAVES];
    logic [MW-1:0]         ptr_d   [N_SLAVES];

    logic [ADDR_WIDTH-1:0] m_addr_a  [N_MASTERS];
    logic [DATA_WIDTH-1:0] m_wdata_a [N_MASTERS];
    logic [SW-1:0]         m_slv     [N_MASTERS];

    logic [MW-1:0]         sel;
    logic                  found;
    logic [MW-1:0]         cur;

    function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] idx);
        if (int'(idx) == N_MASTERS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_addr_a[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata_a[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_slv[i]     = m_addr[i*ADDR_WIDTH + ADDR_WIDTH - 1 -: SW];
        end
    end

    always_comb begin
        sel   = '0;
        found = 1'b0;
        cur   = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            cur        = owner_q[j];
            case (state_q[j])
                ST_IDLE: begin
                    // Scan masters starting at the pointer, wrapping around.
                    found = 1'b0;
                    sel   = ptr_q[j];
                    for (int k = 0; k < N_MASTERS; k++) begin
                        if (!found && m_req[sel] && (m_slv[sel] == SW'(j))) begin
                            found      = 1'b1;
                            owner_d[j] = sel;
                            state_d[j] = ST_REQ;
                        end
                        sel = next_idx(sel);
                    end
                end
                ST_REQ: begin
                    if (!m_req[cur]) begin
                        state_d[j] = ST_IDLE;
                        ptr_d[j]   = next_idx(cur);
                    end else if (s_ack[j]) begin
                        if (m_cmd[cur]) begin
                            state_d[j] = ST_IDLE;
                            ptr_d[j]   = next_idx(cur);
                        end else begin
                            state_d[j] = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (s_resp[j]) begin
                        state_d[j] = ST_IDLE;
                        ptr_d[j]   = next_idx(cur);
                    end
                end
                default: state_d[j] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_SLAVES; j++) begin
                state_q[j] <= ST_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < N_SLAVES; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    // Routing is purely combinational from the registered grant, so ack and
    // read data reach the master with no added latency.
    always_comb begin
        m_ack     = '0;
        m_resp    = '0;
        m_rdata   = '0;
        s_req     = '0;
        s_addr    = '0;
        s_cmd     = '0;
        s_wdata   = '0;
        dbg_state = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            dbg_state[2*j +: 2] = state_q[j];
            if (state_q[j] == ST_REQ && m_req[owner_q[j]]) begin
                s_req[j]                            = 1'b1;
                s_addr[j*ADDR_WIDTH +: ADDR_WIDTH]  = m_addr_a[owner_q[j]];
                s_cmd[j]                            = m_cmd[owner_q[j]];
                s_wdata[j*DATA_WIDTH +: DATA_WIDTH] = m_wdata_a[owner_q[j]];
            end
            for (int i = 0; i < N_MASTERS; i++) begin
                if (owner_q[j] == MW'(i)) begin
                    if (state_q[j] == ST_REQ) begin
                        m_ack[i] = m_ack[i] | (s_ack[j] & m_req[i]);
                    end
                    if (state_q[j] == ST_WAIT) begin
                        m_resp[i] = m_resp[i] | s_resp[j];
                        m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = m_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                            | s_rdata[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_rr.sv
// Bench for cross_bar_rr: directed scenarios with literal expectations, then
// randomized masters/slaves checked every cycle against a behavioural model.
module tb_cross_bar_rr;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_req;
    logic [NM*AW-1:0]  m_addr;
    logic [NM-1:0]     m_cmd;
    logic [NM*DW-1:0]  m_wdata;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_resp;
    logic [NM*DW-1:0]  m_rdata;
    logic [NS-1:0]     s_req;
    logic [NS*AW-1:0]  s_addr;
    logic [NS-1:0]     s_cmd;
    logic [NS*DW-1:0]  s_wdata;
    logic [NS-1:0]     s_ack;
    logic [NS-1:0]     s_resp;
    logic [NS*DW-1:0]  s_rdata;
    logic [2*NS-1:0]   dbg_state;

    cross_bar_rr #(
        .N_MASTERS (NM),
        .N_SLAVES  (NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_resp   (m_resp),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_cmd    (s_cmd),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_resp   (s_resp),
        .s_rdata  (s_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ph    [NS];     // 0 free, 1 presenting request, 2 awaiting read data
    int own   [NS];
    int ptr_m [NS];
    logic [NM-1:0]    last_ack, last_resp;
    logic [NM-1:0]    prev_req, prev_ack;
    logic [NM-1:0]    prev_cmd;
    logic [NM*AW-1:0] prev_addr;
    logic [NM*DW-1:0] prev_wdata;
    logic             prev_rst;

    logic [NM-1:0]    e_ack, e_resp;
    logic [NM*DW-1:0] e_rdata;
    logic [NS-1:0]    e_sreq, e_scmd;
    logic [NS*AW-1:0] e_saddr;
    logic [NS*DW-1:0] e_swdata;
    logic [2*NS-1:0]  e_dbg;

    function automatic int slave_of(input logic [AW-1:0] a);
        return int'(a[AW-1 -: 2]);
    endfunction

    always @(negedge clk) begin
        e_ack = '0; e_resp = '0; e_rdata = '0; e_sreq = '0; e_scmd = '0;
        e_saddr = '0; e_swdata = '0; e_dbg = '0;
        if (!rst_n) begin
            for (int j = 0; j < NS; j++) begin
                ph[j] = 0; own[j] = 0; ptr_m[j] = 0;
            end
        end else begin
            for (int j = 0; j < NS; j++) begin
                int o;
                o = own[j];
                e_dbg[2*j +: 2] = 2'(ph[j]);
                if (ph[j] == 1 && m_req[o]) begin
                    e_sreq[j]             = 1'b1;
                    e_saddr[j*AW +: AW]   = m_addr[o*AW +: AW];
                    e_scmd[j]             = m_cmd[o];
                    e_swdata[j*DW +: DW]  = m_wdata[o*DW +: DW];
                    e_ack[o]              = s_ack[j];
                end
                if (ph[j] == 2) begin
                    e_resp[o]            = s_resp[j];
                    e_rdata[o*DW +: DW]  = s_rdata[j*DW +: DW];
                end
            end
        end
        check("m_ack", m_ack, e_ack);
        check("m_resp", m_resp, e_resp);
        check("m_rdata", m_rdata, e_rdata);
        check("s_req", s_req, e_sreq);
        check("s_addr", s_addr, e_saddr);
        check("s_cmd", s_cmd, e_scmd);
        check("s_wdata", s_wdata, e_swdata);
        check("dbg_state", dbg_state, e_dbg);

        // Master request fields must hold while a request waits for its ack.
        if (rst_n && prev_rst) begin
            for (int i = 0; i < NM; i++) begin
                if (prev_req[i] && !prev_ack[i] && m_req[i]) begin
                    check("m_stable", {m_cmd[i], m_addr[i*AW +: AW], m_wdata[i*DW +: DW]},
                          {prev_cmd[i], prev_addr[i*AW +: AW], prev_wdata[i*DW +: DW]});
                end
            end
        end

        // Advance the model to the state it holds after the coming edge.
        if (rst_n) begin
            for (int j = 0; j < NS; j++) begin
                case (ph[j])
                    0: begin
                        for (int k = 0; k < NM; k++) begin
                            int c;
                            c = (ptr_m[j] + k) % NM;
                            if (ph[j] == 0 && m_req[c] && slave_of(m_addr[c*AW +: AW]) == j) begin
                                own[j] = c;
                                ph[j]  = 1;
                            end
                        end
                    end
                    1: begin
                        if (!m_req[own[j]]) begin
                            ph[j] = 0; ptr_m[j] = (own[j] + 1) % NM;
                        end else if (s_ack[j]) begin
                            if (m_cmd[own[j]]) begin
                                ph[j] = 0; ptr_m[j] = (own[j] + 1) % NM;
                            end else begin
                                ph[j] = 2;
                            end
                        end
                    end
                    default: begin
                        if (s_resp[j]) begin
                            ph[j] = 0; ptr_m[j] = (own[j] + 1) % NM;
                        end
                    end
                endcase
            end
        end
        last_ack   = m_ack;
        last_resp  = m_resp;
        prev_req   = m_req;
        prev_ack   = m_ack;
        prev_cmd   = m_cmd;
        prev_addr  = m_addr;
        prev_wdata = m_wdata;
        prev_rst   = rst_n;
    end

    // ---------------- driver tasks ----------------
    int mst_st [NM];
    int wcnt   [NM];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic req, input logic cmd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_req[i]            = req;
        m_cmd[i]            = cmd;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic new_txn(input int i);
        logic [1:0]  slv;
        logic [31:0] r;
        slv = 2'($urandom_range(0, NS-1));
        r   = $urandom;
        set_m(i, 1'b1, 1'($urandom_range(0, 1)), {slv, r[29:0]}, $urandom);
        mst_st[i] = 1;
    endtask

    task automatic drive_random();
        for (int i = 0; i < NM; i++) begin
            if (!rst_n) begin
                m_req[i] = 1'b0; mst_st[i] = 0;
            end else begin
                case (mst_st[i])
                    0: if ($urandom_range(0, 3) == 0) new_txn(i);
                    1: begin
                        if (last_ack[i]) begin
                            if (m_cmd[i]) begin
                                if ($urandom_range(0, 1) == 1) new_txn(i);
                                else begin m_req[i] = 1'b0; mst_st[i] = 0; end
                            end else begin
                                m_req[i] = 1'b0; mst_st[i] = 2; wcnt[i] = 0;
                            end
                        end else if ($urandom_range(0, 19) == 0) begin
                            m_req[i] = 1'b0; mst_st[i] = 0;
                        end
                    end
                    default: begin
                        wcnt[i]++;
                        if (last_resp[i] || wcnt[i] > 200) mst_st[i] = 0;
                    end
                endcase
            end
        end
        s_ack   = 4'($urandom_range(0, 15));
        s_resp  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------- reset and stimulus ----------------
    initial begin
        logic [DW-1:0] g;
        rst_n = 1'b0; m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
        s_ack = '0; s_resp = '0; s_rdata = '0;
        for (int i = 0; i < NM; i++) begin mst_st[i] = 0; wcnt[i] = 0; end
        repeat (3) mid();
        check("rst_outs", {m_ack, m_resp, s_req, s_cmd, dbg_state}, '0);
        check("rst_data", {m_rdata, s_wdata}, '0);
        step(); rst_n = 1'b1;
        mid(); check("post_rst_sreq", s_req, '0);

        // single write M0 -> S1
        step(); set_m(0, 1'b1, 1'b1, 32'h4000_0010, 32'hA5);
        mid(); check("t1_sreq_early", s_req, '0);
        step(); s_ack[1] = 1'b1;
        mid();
        check("t1_sreq", s_req, 4'b0010);
        check("t1_wdata", s_wdata[63:32], 32'hA5);
        check("t1_addr", s_addr[63:32], 32'h4000_0010);
        check("t1_ack", m_ack, 4'b0001);
        step(); m_req[0] = 1'b0; s_ack = '0;
        mid(); check("t1_idle", dbg_state[3:2], 2'd0);

        // read M2 -> S3 with three-cycle response
        step(); set_m(2, 1'b1, 1'b0, 32'hC000_0000, 32'h0);
        mid();
        step(); s_ack[3] = 1'b1;
        mid();
        check("t2_ack", m_ack, 4'b0100);
        check("t2_sreq", s_req, 4'b1000);
        step(); m_req[2] = 1'b0; s_ack = '0;
        mid(); check("t2_wait", dbg_state[7:6], 2'd2); check("t2_noresp", m_resp, '0);
        step(); mid(); check("t2_noresp2", m_resp, '0);
        step(); s_resp[3] = 1'b1; s_rdata[127:96] = 32'hDEAD_BEEF;
        mid();
        check("t2_resp", m_resp, 4'b0100);
        check("t2_rdata", m_rdata[95:64], 32'hDEAD_BEEF);
        step(); s_resp = '0; s_rdata = '0;
        mid(); check("t2_idle", dbg_state[7:6], 2'd0);

        // contention: all masters write S0 continuously, immediate acks
        exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        step();
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 32'(i * 16), 32'(i));
        s_ack[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mid();
            if (m_ack != '0) begin
                if (exp_q.size() == 0) check("t3_extra", m_ack, '0);
                else begin
                    g = exp_q.pop_front();
                    check("t3_grant", m_ack, 256'd1 << g);
                end
            end
            if (c < 9) step();
        end
        step(); m_req = '0; s_ack = '0;
        check("t3_left", 32'(exp_q.size()), 0);
        mid();

        // parallel: M0->S0 and M1->S2, then M3->S0 queued behind M0
        step();
        set_m(0, 1'b1, 1'b1, 32'h0000_0040, 32'h11);
        set_m(1, 1'b1, 1'b1, 32'h8000_0080, 32'h22);
        mid();
        step(); set_m(3, 1'b1, 1'b1, 32'h0000_0300, 32'h33);
        mid();
        check("t4_par", s_req, 4'b0101);
        check("t4_wd0", s_wdata[31:0], 32'h11);
        check("t4_wd2", s_wdata[95:64], 32'h22);
        step(); s_ack = 4'b0101;
        mid(); check("t4_ack", m_ack, 4'b0011);
        step(); m_req[0] = 1'b0; m_req[1] = 1'b0; s_ack = '0;
        mid(); check("t4_gap", s_req, '0);
        step(); s_ack[0] = 1'b1;
        mid();
        check("t4_m3_sreq", s_req, 4'b0001);
        check("t4_m3_addr", s_addr[31:0], 32'h0000_0300);
        check("t4_m3_ack", m_ack, 4'b1000);
        step(); m_req[3] = 1'b0; s_ack = '0;
        mid();
        // move S2 pointer to 0 with a write from M3
        step(); set_m(3, 1'b1, 1'b1, 32'h8000_0000, 32'h44);
        mid();
        step(); s_ack[2] = 1'b1;
        mid(); check("t4_s2_ack", m_ack, 4'b1000);
        step(); m_req[3] = 1'b0; s_ack = '0;
        mid();

        // abort: M1 drops its S2 request before any ack
        step(); set_m(1, 1'b1, 1'b0, 32'h8000_0004, 32'h0);
        mid();
        step(); mid(); check("t5_req", s_req, 4'b0100);
        step(); m_req[1] = 1'b0;
        mid(); check("t5_sreq_low", s_req, '0); check("t5_noack", m_ack, '0);
        step();
        set_m(0, 1'b1, 1'b1, 32'h8000_0008, 32'h55);
        set_m(3, 1'b1, 1'b1, 32'h8000_000C, 32'h66);
        mid();
        step(); mid(); check("t5_ptr", s_addr[95:64], 32'h8000_000C);
        step(); s_ack[2] = 1'b1;
        mid(); check("t5_ack3", m_ack, 4'b1000);
        step(); m_req[3] = 1'b0; s_ack = '0;
        mid();
        step(); s_ack[2] = 1'b1;
        mid(); check("t5_ack0", m_ack, 4'b0001);
        step(); m_req[0] = 1'b0; s_ack = '0;
        mid();

        // reset while a read waits for data
        step(); set_m(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        mid();
        step(); s_ack[1] = 1'b1;
        mid(); check("t6_ack", m_ack, 4'b0001);
        step(); m_req[0] = 1'b0; s_ack = '0;
        mid(); check("t6_wait", dbg_state[3:2], 2'd2);
        step(); rst_n = 1'b0; s_resp[1] = 1'b1; s_rdata[63:32] = 32'h1234_5678;
        mid();
        check("t6_rst_resp", m_resp, '0);
        check("t6_rst_rdata", m_rdata, '0);
        check("t6_rst_state", dbg_state, '0);
        step(); rst_n = 1'b1;
        mid(); check("t6_late_resp", m_resp, '0); check("t6_late_rdata", m_rdata, '0);
        step(); s_resp = '0; s_rdata = '0;
        mid();

        // randomized traffic with a reset pulse in the middle
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            drive_random();
        end
        step(); m_req = '0; s_ack = '0; s_resp = '0;
        repeat (3) mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
